// File: rtl/z80_io_timer.sv
// Z80 I/O-mapped down-counter timer with wait-state insertion and a mode-2 interrupt vector.
// Define Z80_TIMER_DAISY_EN to add the IEI/IEO priority daisy-chain ports.
module z80_io_timer #(
    parameter logic [7:0] BASE_PORT   = 8'h40,
    parameter int         PRESCALE    = 16,
    parameter int         WAIT_STATES = 1
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic       nIORQ,
    input  logic       nRD,
    input  logic       nWR,
    input  logic       nM1,
    output logic       nINT,
    output logic       nWAIT
`ifdef Z80_TIMER_DAISY_EN
    ,
    input  logic       IEI,
    output logic       IEO
`endif
);

    localparam logic [15:0] PS_MAX  = 16'(PRESCALE - 1);
    localparam logic [2:0]  WS_INIT = 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

    state_t      state_q;
    logic [2:0]  wait_cnt_q;
    logic        nwait_q;

    logic        run_q, run_d, ie_q, ie_d, auto_q, auto_d, pending_q, pending_d;
    logic [7:0]  reload_q, reload_d, count_q, count_d, dout_q, dout_d;
    logic [6:0]  vec_q, vec_d;
    logic [15:0] prescale_q, prescale_d;
    logic        rd_act_q, rd_act_d, ack_act_q, ack_act_d, act_prev_q, act_prev_d;
    logic        nint_q, nint_d;

    logic        iei, hit, access_now, ack_now, acc_start, ack_start, wr_start, rd_start;
    logic        tick, cnt_wr;
    logic [7:0]  rd_mux;

`ifdef Z80_TIMER_DAISY_EN
    assign iei = IEI;
    assign IEO = IEI & ~(pending_q & ie_q);
`else
    assign iei = 1'b1;
`endif

    // A bus cycle is acted on only on its first sample, so wait states never repeat an action.
    assign hit        = (A[7:2] == BASE_PORT[7:2]);
    assign access_now = ~nIORQ & nM1 & hit & (~nRD | ~nWR);
    assign ack_now    = ~nIORQ & ~nM1;
    assign acc_start  = access_now & ~act_prev_q;
    assign ack_start  = ack_now & ~act_prev_q & ~nint_q & iei;
    assign wr_start   = acc_start & ~nWR;
    assign rd_start   = acc_start & ~nRD;

    always_comb begin
        rd_mux = 8'h00;
        case (A[1:0])
            2'd0: rd_mux = {pending_q, 4'b0000, auto_q, ie_q, run_q};
            2'd1: rd_mux = reload_q;
            2'd2: rd_mux = count_q;
            default: rd_mux = {vec_q, 1'b0};
        endcase
    end

    always_comb begin
        run_d      = run_q;
        ie_d       = ie_q;
        auto_d     = auto_q;
        pending_d  = pending_q;
        reload_d   = reload_q;
        count_d    = count_q;
        vec_d      = vec_q;
        prescale_d = prescale_q;
        dout_d     = dout_q;
        rd_act_d   = rd_act_q;
        ack_act_d  = ack_act_q;
        tick       = 1'b0;
        cnt_wr     = 1'b0;
        act_prev_d = access_now | ack_now;
        nint_d     = ~(pending_q & ie_q & iei);

        if (rd_start)   rd_act_d = 1'b1;
        else if (nIORQ) rd_act_d = 1'b0;
        if (ack_start)  ack_act_d = 1'b1;
        else if (nIORQ) ack_act_d = 1'b0;

        if (rd_start)       dout_d = rd_mux;
        else if (ack_start) dout_d = {vec_q, 1'b0};

        if (ack_start) pending_d = 1'b0;

        if (wr_start) begin
            case (A[1:0])
                2'd0: begin
                    run_d  = D_in[0];
                    ie_d   = D_in[1];
                    auto_d = D_in[2];
                    if (D_in[7]) pending_d = 1'b0;
                end
                2'd1: reload_d = D_in;
                2'd2: begin
                    count_d = D_in;
                    cnt_wr  = 1'b1;
                end
                default: vec_d = D_in[7:1];
            endcase
        end

        if (run_q) begin
            if (prescale_q == PS_MAX) begin
                prescale_d = 16'h0000;
                tick       = 1'b1;
            end else begin
                prescale_d = prescale_q + 16'd1;
            end
        end

        // A COUNT write on the decrement edge cancels the whole terminal event.
        if (tick && !cnt_wr) begin
            count_d = count_q - 8'd1;
            if (count_q == 8'd1) begin
                pending_d = 1'b1;
                if (auto_q) count_d = reload_q;
                else        run_d   = 1'b0;
            end
        end

        if (cnt_wr) prescale_d = 16'h0000;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            run_q      <= 1'b0;
            ie_q       <= 1'b0;
            auto_q     <= 1'b0;
            pending_q  <= 1'b0;
            reload_q   <= 8'hFF;
            count_q    <= 8'h00;
            vec_q      <= 7'h00;
            prescale_q <= 16'h0000;
            dout_q     <= 8'h00;
            rd_act_q   <= 1'b0;
            ack_act_q  <= 1'b0;
            act_prev_q <= 1'b0;
            nint_q     <= 1'b1;
        end else begin
            run_q      <= run_d;
            ie_q       <= ie_d;
            auto_q     <= auto_d;
            pending_q  <= pending_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            vec_q      <= vec_d;
            prescale_q <= prescale_d;
            dout_q     <= dout_d;
            rd_act_q   <= rd_act_d;
            ack_act_q  <= ack_act_d;
            act_prev_q <= act_prev_d;
            nint_q     <= nint_d;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 3'd0;
            nwait_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc_start || ack_start) begin
                        if (WAIT_STATES > 0) begin
                            state_q    <= S_WAIT;
                            wait_cnt_q <= WS_INIT;
                            nwait_q    <= 1'b0;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q <= S_HOLD;
                        nwait_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                S_HOLD: begin
                    if (nIORQ) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    nwait_q <= 1'b1;
                end
            endcase
        end
    end

    assign D_oe  = ~nIORQ & ((rd_act_q & ~nRD) | ack_act_q);
    assign D_out = dout_q;
    assign nINT  = nint_q;
    assign nWAIT = nwait_q;

endmodule

// File: tb/tb_z80_io_timer.sv
// Bench for z80_io_timer: register vectors, wait states, one-shot, ack, auto-reload, reset mid-read.
module tb_z80_io_timer;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] D_in = 8'h00;
    logic       nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nM1 = 1'b1;
    logic [7:0] D_out;
    logic       D_oe, nINT, nWAIT;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] wport;
        logic [7:0] wdata;
        logic [7:0] rport;
        logic [7:0] exp;
        logic       hit;
    } vec_t;
    vec_t vecs[9];

    z80_io_timer #(.BASE_PORT(8'h40), .PRESCALE(16), .WAIT_STATES(2)) dut (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1), .nINT(nINT), .nWAIT(nWAIT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All bus tasks are entered in the low clock phase and return just after a falling edge.
    task automatic io_write(input logic [7:0] port, input logic [7:0] data, output int waits, output int start);
        int i;
        A = port; D_in = data; nIORQ = 1'b0; nWR = 1'b0;
        start = cyc + 1; waits = 0; i = 0;
        do begin
            @(negedge CLK); i++;
            if (nWAIT === 1'b0) waits++;
        end while (nWAIT !== 1'b1 && i < 20);
        nIORQ = 1'b1; nWR = 1'b1;
        @(negedge CLK);
    endtask

    task automatic io_read(input logic [7:0] port, output logic [7:0] data, output logic oe,
                           output logic oe_after, output int waits);
        int i;
        A = port; nIORQ = 1'b0; nRD = 1'b0;
        waits = 0; i = 0;
        do begin
            @(negedge CLK); i++;
            if (nWAIT === 1'b0) waits++;
        end while (nWAIT !== 1'b1 && i < 20);
        data = D_out; oe = D_oe;
        nIORQ = 1'b1; nRD = 1'b1;
        #1 oe_after = D_oe;
        @(negedge CLK);
    endtask

    task automatic read_chk(input logic [7:0] port, input logic [7:0] exp, input string name);
        logic [7:0] d, e;
        logic oe, oe_after;
        int w;
        exp_q.push_back(exp);
        io_read(port, d, oe, oe_after, w);
        e = exp_q.pop_front();
        check(name, int'(d), int'(e));
        check({name, "_oe"}, int'(oe), 1);
        check({name, "_oe_drop"}, int'(oe_after), 0);
        check({name, "_waits"}, w, 2);
    endtask

    task automatic do_ack(output logic oe1, output logic [7:0] dout1, output logic nint1,
                          output logic nint2, output int waits, output logic oe_after);
        int i;
        nM1 = 1'b0;
        @(negedge CLK);
        nIORQ = 1'b0;
        waits = 0; i = 0;
        oe1 = 1'b0; dout1 = 8'h00; nint1 = 1'b1; nint2 = 1'b1;
        do begin
            @(negedge CLK); i++;
            if (nWAIT === 1'b0) waits++;
            if (i == 1) begin oe1 = D_oe; dout1 = D_out; nint1 = nINT; end
            if (i == 2) nint2 = nINT;
        end while ((nWAIT !== 1'b1 || i < 2) && i < 20);
        nIORQ = 1'b1; nM1 = 1'b1;
        #1 oe_after = D_oe;
        @(negedge CLK);
    endtask

    task automatic wait_nint(output int at);
        int n;
        n = 0;
        while (nINT !== 1'b0 && n < 300) begin
            @(negedge CLK); n++;
        end
        at = cyc;
    endtask

    initial begin
        int w, s, s2, t;
        logic [7:0] d, dv;
        logic oe, oe_after, n1, n2;

        vecs[0] = '{8'h41, 8'h5A, 8'h41, 8'h5A, 1'b1};
        vecs[1] = '{8'h43, 8'h21, 8'h43, 8'h20, 1'b1};
        vecs[2] = '{8'h40, 8'h86, 8'h40, 8'h06, 1'b1};
        vecs[3] = '{8'h40, 8'h00, 8'h40, 8'h00, 1'b1};
        vecs[4] = '{8'h42, 8'hA5, 8'h42, 8'hA5, 1'b1};
        vecs[5] = '{8'h45, 8'h77, 8'h41, 8'h5A, 1'b1};
        vecs[6] = '{8'h47, 8'hFF, 8'h43, 8'h20, 1'b1};
        vecs[7] = '{8'h41, 8'h05, 8'h44, 8'h00, 1'b0};
        vecs[8] = '{8'h43, 8'hFF, 8'h43, 8'hFE, 1'b1};

        // Reset
        repeat (3) @(negedge CLK);
        check("rst_nint", int'(nINT), 1);
        check("rst_nwait", int'(nWAIT), 1);
        check("rst_oe", int'(D_oe), 0);
        nRESET = 1'b1;
        @(negedge CLK);
        read_chk(8'h40, 8'h00, "rst_ctrl");
        read_chk(8'h41, 8'hFF, "rst_reload");
        read_chk(8'h42, 8'h00, "rst_count");
        read_chk(8'h43, 8'h00, "rst_vector");

        // Wait states and decode miss
        io_write(8'h41, 8'h05, w, s);
        check("t2_wr_waits", w, 2);
        read_chk(8'h41, 8'h05, "t2_rd");
        io_write(8'h44, 8'h99, w, s);
        check("t2_miss_wr_waits", w, 0);
        io_read(8'h44, d, oe, oe_after, w);
        check("t2_miss_rd_oe", int'(oe), 0);
        check("t2_miss_rd_waits", w, 0);

        // Register vectors
        for (int i = 0; i < 9; i++) begin
            io_write(vecs[i].wport, vecs[i].wdata, w, s);
            if (vecs[i].hit) begin
                read_chk(vecs[i].rport, vecs[i].exp, $sformatf("vec%0d", i));
            end else begin
                io_read(vecs[i].rport, d, oe, oe_after, w);
                check($sformatf("vec%0d_miss_oe", i), int'(oe), 0);
                check($sformatf("vec%0d_miss_waits", i), w, 0);
            end
        end

        // One-shot
        io_write(8'h42, 8'h03, w, s);
        io_write(8'h40, 8'h03, w, s);
        wait_nint(t);
        check("t3_nint_latency", t - s, 49);
        read_chk(8'h40, 8'h82, "t3_ctrl");
        read_chk(8'h42, 8'h00, "t3_count");
        repeat (40) @(negedge CLK);
        read_chk(8'h42, 8'h00, "t3_count_hold");

        // Interrupt acknowledge
        io_write(8'h43, 8'h21, w, s);
        do_ack(oe, dv, n1, n2, w, oe_after);
        check("t4_ack_oe", int'(oe), 1);
        check("t4_ack_vec", int'(dv), 8'h20);
        check("t4_nint_at_start", int'(n1), 0);
        check("t4_nint_after", int'(n2), 1);
        check("t4_ack_waits", w, 2);
        check("t4_ack_oe_drop", int'(oe_after), 0);
        read_chk(8'h40, 8'h02, "t4_ctrl");
        do_ack(oe, dv, n1, n2, w, oe_after);
        check("t4_noack_oe", int'(oe), 0);
        check("t4_noack_waits", w, 0);

        // Auto-reload and COUNT write on the terminal edge
        io_write(8'h41, 8'h02, w, s);
        io_write(8'h42, 8'h02, w, s);
        io_write(8'h40, 8'h87, w, s);
        wait_nint(t);
        check("t5_first_tc", t - s, 33);
        do_ack(oe, dv, n1, n2, w, oe_after);
        check("t5_ack1_oe", int'(oe), 1);
        wait_nint(t);
        check("t5_second_tc", t - s, 65);
        do_ack(oe, dv, n1, n2, w, oe_after);
        check("t5_ack2_oe", int'(oe), 1);
        while (cyc < s + 95) @(negedge CLK);
        io_write(8'h42, 8'h05, w, s2);
        check("t5_edge_align", s2 - s, 96);
        check("t5_nint_idle", int'(nINT), 1);
        read_chk(8'h40, 8'h07, "t5_ctrl");
        read_chk(8'h42, 8'h05, "t5_count");

        // Reset in the middle of a read with nWAIT low
        A = 8'h42; nIORQ = 1'b0; nRD = 1'b0;
        @(negedge CLK);
        check("t6_pre_nwait", int'(nWAIT), 0);
        check("t6_pre_oe", int'(D_oe), 1);
        #2 nRESET = 1'b0;
        #1;
        check("t6_async_oe", int'(D_oe), 0);
        check("t6_async_nwait", int'(nWAIT), 1);
        nIORQ = 1'b1; nRD = 1'b1;
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
        check("t6_nint", int'(nINT), 1);
        read_chk(8'h40, 8'h00, "t6_ctrl");
        read_chk(8'h41, 8'hFF, "t6_reload");
        read_chk(8'h42, 8'h00, "t6_count");
        read_chk(8'h43, 8'h00, "t6_vector");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z80_io_timer.md
Name: z80_io_timer

Overview:
- Z80 bus responder: I/O-mapped down-counter timer that sits on the z80_if bus alongside memory.
- Decodes I/O read/write cycles to its four ports and inserts programmable wait states through nWAIT.
- Raises nINT on terminal count and answers the CPU's mode-2 interrupt acknowledge (nM1 and nIORQ both low) by driving its vector onto D.
- Gives the top-level bench a second bus agent that drives nWAIT and nINT, both of which the CPU samples.

Parameters:
- BASE_PORT, 8'h40, I/O base address; the block decodes A[7:2] == BASE_PORT[7:2].
- PRESCALE, 16, CLK cycles per counter decrement; legal range 1..65535.
- WAIT_STATES, 1, nWAIT low cycles per decoded I/O access; legal range 0..7.

Ports:
- CLK  in  1  system clock, same clock as the CPU.
- nRESET  in  1  asynchronous, active-low reset.
- A  in  8  low address byte (I/O port number).
- D_in  in  8  data bus from CPU.
- D_out  out  8  data driven to CPU.
- D_oe  out  1  high when D_out must drive the shared D bus.
- nIORQ  in  1  I/O request, active low.
- nRD  in  1  read strobe, active low.
- nWR  in  1  write strobe, active low.
- nM1  in  1  opcode fetch / interrupt-acknowledge qualifier, active low.
- nINT  out  1  interrupt request, active low.
- nWAIT  out  1  wait request, active low.

Behaviour:
- Register map (offset = A[1:0]):
  - 0 CTRL R/W: bit0 RUN, bit1 IE, bit2 AUTO; bit7 reads PENDING; other bits read 0.
  - 1 RELOAD R/W.
  - 2 COUNT R/W.
  - 3 VECTOR R/W; bit0 always reads and drives 0.
- Reset values: CTRL=0, RELOAD=8'hFF, COUNT=0, VECTOR=0, PENDING=0, prescaler=0. Outputs: D_out=0, D_oe=0, nINT=1, nWAIT=1.
- Access detect: rising CLK with nIORQ=0, nM1=1, address hit and (nRD=0 or nWR=0), while the previous sample was not an access, marks access start. Exactly one action per bus cycle.
- Write: D_in is captured at access start and the target register updates on that edge.
- Read: D_out is loaded at access start (snapshot of the register, so COUNT is stable for the whole cycle).
  - D_oe = registered access-active AND nRD=0; it drops combinationally as soon as nRD or nIORQ deasserts.
- Wait FSM, states IDLE, WAIT, HOLD:
  - IDLE -> WAIT on access start if WAIT_STATES>0; otherwise IDLE -> HOLD.
  - nWAIT is low only in WAIT, for exactly WAIT_STATES cycles, then WAIT -> HOLD.
  - HOLD -> IDLE when nIORQ=1.
  - Interrupt acknowledge uses the same FSM.
- Counter:
  - While RUN=1, the prescaler counts 0..PRESCALE-1; on wrap, COUNT decrements.
  - Terminal event is COUNT going 1->0. It sets PENDING, then:
    - AUTO=1: COUNT<=RELOAD (the pre-write value if RELOAD is written on the same edge).
    - AUTO=0: RUN<=0.
  - RUN=1 with COUNT=0 decrements to 8'hFF (wrap) and produces no terminal event.
  - Writing COUNT clears the prescaler. A COUNT write on the same edge as a terminal event wins: no PENDING set, no reload.
  - Writing RUN=0 freezes COUNT and the prescaler.
- Interrupt:
  - nINT = ~(PENDING & IE), registered.
  - Acknowledge start (nM1=0, nIORQ=0, first sample): D_out<=VECTOR&8'hFE and D_oe high until nIORQ=1; PENDING clears on that edge.
  - A terminal event on the same edge keeps PENDING=1.
  - The block acknowledges only while nINT=0 at ack start. Otherwise it does not drive D.
  - Writing CTRL bit7=1 clears PENDING; writing 0 has no effect.
- Reset mid-access: all state returns to reset values immediately. D_oe and nWAIT release asynchronously.

Optional Feature:
- Macro Z80_TIMER_DAISY_EN.
- When defined, adds ports IEI (in, 1) and IEO (out, 1) for the Z80 priority daisy chain.
  - nINT may assert only when IEI=1.
  - The ack response requires IEI=1.
  - IEO = IEI & ~(PENDING & IE), combinational.
- When undefined: no such ports, IEI is internally tied to 1, and behaviour is exactly as above.

Test Plan:
1. Reset: hold nRESET=0 for 3 cycles -> nINT=1, nWAIT=1, D_oe=0; read CTRL=8'h00, RELOAD=8'hFF, COUNT=8'h00.
2. Wait states, WAIT_STATES=2, BASE_PORT=8'h40: OUT (41h),8'h05 -> nWAIT low exactly 2 CLK cycles; IN (41h) returns 8'h05. Access to port 44h -> nWAIT stays 1, D_oe stays 0.
3. One-shot, PRESCALE=16: RELOAD unused, COUNT=3, CTRL=8'h03 -> nINT falls 48 (+1 registered) cycles later; RUN reads 0; COUNT=0 and stays 0.
4. Interrupt acknowledge: VECTOR=8'h21, then ack cycle -> D_oe high with D_out=8'h20; nINT returns to 1 the cycle after ack start; PENDING=0.
5. Auto-reload: RELOAD=2, COUNT=2, CTRL=8'h07 -> terminal events every 32 cycles. COUNT write of 5 on a terminal edge -> COUNT=5 and PENDING unchanged.
6. Reset mid-read: assert nRESET during IN (42h) with nWAIT low -> D_oe=0 and nWAIT=1 asynchronously; all registers at reset values.
